// File: rtl/operand_loader.sv
// operand_loader
// Serial-to-parallel operand front end. Two operands are shifted in MSB first
// while the framing strobe is high. A complete frame is committed into a
// one-deep output buffer guarded by a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               design enable; low freezes capture (handshake still runs)
//   load              frame strobe, high while bits are presented
//   ser_a, ser_b      serial operand bits, MSB first
//   out_ready         downstream accepts the buffered pair
//   err_clr           clears the sticky error flags (a coincident set wins)
//   out_a, out_b      buffered operands
//   out_valid         buffer holds an unconsumed pair
//   busy              a frame is being shifted in
//   abort_err         sticky: a frame ended short
//   ovf_err           sticky: a completed frame was dropped, buffer full
module operand_loader #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic             ser_a,
    input  logic             ser_b,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_valid,
    output logic             busy,
    output logic             abort_err,
    output logic             ovf_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    // Only the low WIDTH-1 bits of the partial frame are ever needed: the
    // last sampled bit is concatenated on the fly when the frame commits.
    logic [WIDTH-2:0]  sh_a;
    logic [WIDTH-2:0]  sh_b;

    logic              sample;
    logic              last_bit;
    logic              abort;
    logic              drop;
    logic [WIDTH-1:0]  next_a;
    logic [WIDTH-1:0]  next_b;

    always_comb begin
        sample   = ena & load;
        next_a   = {sh_a, ser_a};
        next_b   = {sh_b, ser_b};
        last_bit = (state == SHIFT) && sample && (cnt == CW'(WIDTH - 1));
        abort    = (state == SHIFT) && ena && !load;
        // Commit with a full buffer that is not being drained this edge.
        drop     = last_bit && out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            abort_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample) begin
                        sh_a  <= next_a[WIDTH-2:0];
                        sh_b  <= next_b[WIDTH-2:0];
                        cnt   <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sample) begin
                        sh_a <= next_a[WIDTH-2:0];
                        sh_b <= next_b[WIDTH-2:0];
                        if (last_bit) begin
                            cnt   <= '0;
                            state <= WAIT_LOW;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (abort) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    // Overlong frames are tolerated silently.
                    if (ena && !load) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Output buffer: a commit may land on the same edge as a transfer,
            // in which case valid stays high and the data is replaced.
            if (last_bit && (!out_valid || out_ready)) begin
                out_a     <= next_a;
                out_b     <= next_b;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Sticky flags: clear first so a coincident set takes priority.
            if (err_clr) begin
                abort_err <= 1'b0;
                ovf_err   <= 1'b0;
            end
            if (abort) abort_err <= 1'b1;
            if (drop)  ovf_err   <= 1'b1;
        end
    end

endmodule
